// File: rtl/memory_stage.sv
// Memory-access stage of the RV32I pipeline: issues data-memory requests, aligns and
// extends load data, and owns the MEM/WB register. Stalls upstream while memory is busy.
module memory_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            srst,
  // EX/MEM register contents
  input  logic            valid_m,
  input  logic            reg_write_m,
  input  logic [1:0]      result_src_m,
  input  logic            mem_write_m,
  input  logic [2:0]      funct3_m,
  input  logic [4:0]      rd_m,
  input  logic [XLEN-1:0] alu_result_m,
  input  logic [XLEN-1:0] write_data_m,
  input  logic [XLEN-1:0] pc_plus4_m,
  // data-memory request interface
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_ready,
  // pipeline control
  output logic            stall_m,
  // MEM/WB register contents
  output logic            valid_w,
  output logic            reg_write_w,
  output logic [1:0]      result_src_w,
  output logic [4:0]      rd_w,
  output logic [XLEN-1:0] read_data_w,
  output logic [XLEN-1:0] alu_result_w,
  output logic [XLEN-1:0] pc_plus4_w,
  output logic            misalign_w
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } size_e;

  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic [1:0]      result_src;
    logic [4:0]      rd;
    logic [XLEN-1:0] read_data;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] pc_plus4;
    logic            misalign;
  } wb_t;

  state_e state_q, state_d;
  wb_t    wb_q, wb_d;

  size_e       size;
  logic [1:0]  offset;
  logic        is_load;
  logic        is_access;
  logic        misaligned;
  logic        mem_op;
  logic        req_raw;
  logic        complete;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [XLEN-1:0] load_data;

  // ---------------------------------------------------------------------------
  // Access decode
  // ---------------------------------------------------------------------------
  assign offset    = alu_result_m[1:0];
  assign is_load   = (result_src_m == 2'b01);
  assign is_access = valid_m & (mem_write_m | is_load);

  // Unlisted funct3 codes fall into the word size, so they act as LW/SW.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    size       = SZ_WORD;
    misaligned = 1'b0;
    case (funct3_m[1:0])
      2'b00:   size = SZ_BYTE;
      2'b01:   size = SZ_HALF;
      default: size = SZ_WORD;
    endcase
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = offset[0];
      default: misaligned = |offset;
    endcase
  end

  assign mem_op = is_access & ~misaligned;

  // ---------------------------------------------------------------------------
  // Request FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    req_raw = 1'b0;
    case (state_q)
      IDLE: begin
        req_raw = mem_op;
        if (mem_op && !dmem_ready) state_d = WAIT;
      end
      WAIT: begin
        req_raw = 1'b1;
        if (dmem_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset kills the request combinationally so a pending access is dropped at once.
  assign dmem_req = req_raw & ~srst;
  assign stall_m  = dmem_req & ~dmem_ready;
  assign complete = dmem_req & dmem_ready;

  // ---------------------------------------------------------------------------
  // Store lane steering
  // ---------------------------------------------------------------------------
  assign dmem_we   = mem_write_m;
  assign dmem_addr = {alu_result_m[XLEN-1:2], 2'b00};

  always_comb begin
    dmem_be    = 4'b0000;
    dmem_wdata = write_data_m;
    case (size)
      SZ_BYTE: dmem_wdata = {4{write_data_m[7:0]}};
      SZ_HALF: dmem_wdata = {2{write_data_m[15:0]}};
      default: dmem_wdata = write_data_m;
    endcase
    if (mem_write_m) begin
      case (size)
        SZ_BYTE: dmem_be = 4'b0001 << offset;
        SZ_HALF: dmem_be = 4'b0011 << offset;
        default: dmem_be = 4'b1111;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Load alignment and extension
  // ---------------------------------------------------------------------------
  always_comb begin
    case (offset)
      2'd0:    byte_lane = dmem_rdata[7:0];
      2'd1:    byte_lane = dmem_rdata[15:8];
      2'd2:    byte_lane = dmem_rdata[23:16];
      default: byte_lane = dmem_rdata[31:24];
    endcase
    half_lane = offset[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (funct3_m)
      3'b000:  load_data = {{24{byte_lane[7]}}, byte_lane};
      3'b001:  load_data = {{16{half_lane[15]}}, half_lane};
      3'b100:  load_data = {24'd0, byte_lane};
      3'b101:  load_data = {16'd0, half_lane};
      default: load_data = dmem_rdata;
    endcase
  end

  // ---------------------------------------------------------------------------
  // MEM/WB register: a stall cycle loads an all-zero bubble
  // ---------------------------------------------------------------------------
  always_comb begin
    wb_d = '0;
    if (!stall_m) begin
      wb_d.valid      = valid_m;
      wb_d.reg_write  = valid_m & reg_write_m & ~(is_access & misaligned);
      wb_d.result_src = result_src_m;
      wb_d.rd         = rd_m;
      wb_d.read_data  = (complete & is_load) ? load_data : '0;
      wb_d.alu_result = alu_result_m;
      wb_d.pc_plus4   = pc_plus4_m;
      wb_d.misalign   = is_access & misaligned;
    end
  end

  always_ff @(posedge clk or posedge srst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    if (srst) begin
      state_q <= IDLE;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      wb_q    <= wb_d;
    end
  end

  assign valid_w      = wb_q.valid;
  assign reg_write_w  = wb_q.reg_write;
  assign result_src_w = wb_q.result_src;
  assign rd_w         = wb_q.rd;
  assign read_data_w  = wb_q.read_data;
  assign alu_result_w = wb_q.alu_result;
  assign pc_plus4_w   = wb_q.pc_plus4;
  assign misalign_w   = wb_q.misalign;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed cases followed by random traffic,
// all compared against a word-level behavioural model of the load/store rules.
module tb_memory_stage;

  logic        clk;
  logic        srst;
  logic        valid_m, reg_write_m, mem_write_m;
  logic [1:0]  result_src_m;
  logic [2:0]  funct3_m;
  logic [4:0]  rd_m;
  logic [31:0] alu_result_m, write_data_m, pc_plus4_m;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        stall_m;
  logic        valid_w, reg_write_w, misalign_w;
  logic [1:0]  result_src_w;
  logic [4:0]  rd_w;
  logic [31:0] read_data_w, alu_result_w, pc_plus4_w;

  int errors = 0;
  int checks = 0;

  memory_stage #(.XLEN(32)) dut (
    .clk          (clk),
    .srst         (srst),
    .valid_m      (valid_m),
    .reg_write_m  (reg_write_m),
    .result_src_m (result_src_m),
    .mem_write_m  (mem_write_m),
    .funct3_m     (funct3_m),
    .rd_m         (rd_m),
    .alu_result_m (alu_result_m),
    .write_data_m (write_data_m),
    .pc_plus4_m   (pc_plus4_m),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_be      (dmem_be),
    .dmem_wdata   (dmem_wdata),
    .dmem_rdata   (dmem_rdata),
    .dmem_ready   (dmem_ready),
    .stall_m      (stall_m),
    .valid_w      (valid_w),
    .reg_write_w  (reg_write_w),
    .result_src_w (result_src_w),
    .rd_w         (rd_w),
    .read_data_w  (read_data_w),
    .alu_result_w (alu_result_w),
    .pc_plus4_w   (pc_plus4_w),
    .misalign_w   (misalign_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Load result from the architectural rules: pick the byte/half by address, then extend.
  function automatic logic [31:0] load_model(input logic [2:0] f3, input int off, input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
      3'b001:  return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  // One instruction through MEM, with `waits` not-ready cycles before completion.
  task automatic run_op(input bit ld, input bit st, input logic [1:0] rs, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdata,
                        input logic [4:0] rd, input bit rw, input int waits);
    int          size;
    bit          mis, go;
    logic [31:0] exp_be, exp_wd, exp_rd, pc4;
    size   = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    mis    = (ld || st) && ((addr % size) != 0);
    go     = (ld || st) && !mis;
    exp_be = st ? ((((32'd1 << size) - 1) << (addr % 4)) & 32'hF) : 32'd0;
    exp_wd = (size == 1) ? (wd & 32'hFF) * 32'h0101_0101 :
             (size == 2) ? (wd & 32'hFFFF) * 32'h0001_0001 : wd;
    exp_rd = (go && ld) ? load_model(f3, int'(addr % 4), rdata) : 32'd0;
    pc4    = $urandom;

    valid_m      = 1'b1;
    reg_write_m  = rw;
    result_src_m = ld ? 2'b01 : rs;
    mem_write_m  = st;
    funct3_m     = f3;
    rd_m         = rd;
    alu_result_m = addr;
    write_data_m = wd;
    pc_plus4_m   = pc4;

    for (int i = 0; i < (go ? waits : 0); i++) begin
      dmem_ready = 1'b0;
      dmem_rdata = $urandom;
      #1;
      check("wait_req", dmem_req, 1);
      check("wait_stall", stall_m, 1);
      check("wait_addr", dmem_addr, addr & ~32'd3);
      check("wait_be", dmem_be, exp_be);
      @(posedge clk); #1;
      check("bubble_valid", valid_w, 0);
      check("bubble_regwrite", reg_write_w, 0);
      check("bubble_misalign", misalign_w, 0);
    end

    dmem_ready = go ? 1'b1 : 1'($urandom_range(0, 1));
    dmem_rdata = rdata;
    #1;
    check("req", dmem_req, go);
    check("stall", stall_m, 0);
    if (go) begin
      check("addr", dmem_addr, addr & ~32'd3);
      check("we", dmem_we, st);
      check("be", dmem_be, exp_be);
      if (st) check("wdata", dmem_wdata, exp_wd);
    end
    @(posedge clk); #1;
    check("wb_valid", valid_w, 1);
    check("wb_regwrite", reg_write_w, rw && !mis);
    check("wb_misalign", misalign_w, mis);
    check("wb_read_data", read_data_w, exp_rd);
    check("wb_rd", rd_w, rd);
    check("wb_alu", alu_result_w, addr);
    check("wb_pc4", pc_plus4_w, pc4);
    check("wb_src", result_src_w, ld ? 2'b01 : rs);
  endtask

  initial begin
    int kind;
    // Reset with a live aligned load presented: no request may escape.
    srst = 1'b1;
    valid_m = 1'b1; reg_write_m = 1'b1; result_src_m = 2'b01; mem_write_m = 1'b0;
    funct3_m = 3'b010; rd_m = 5'd1; alu_result_m = 32'h100; write_data_m = 32'd0;
    pc_plus4_m = 32'h4; dmem_ready = 1'b0; dmem_rdata = 32'd0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_req", dmem_req, 0);
    check("rst_stall", stall_m, 0);
    check("rst_valid", valid_w, 0);
    check("rst_regwrite", reg_write_w, 0);
    check("rst_read_data", read_data_w, 0);
    check("rst_alu", alu_result_w, 0);
    check("rst_pc4", pc_plus4_w, 0);
    check("rst_rd", rd_w, 0);
    check("rst_misalign", misalign_w, 0);
    srst = 1'b0;
    valid_m = 1'b0;

    // Directed cases from the block's intended use.
    run_op(1, 0, 2'b01, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 5'd5, 1, 0);  // LW
    run_op(1, 0, 2'b01, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, 5'd6, 1, 0);  // LB
    run_op(1, 0, 2'b01, 3'b100, 32'h103, 32'h0, 32'h80FF_1234, 5'd7, 1, 0);  // LBU
    run_op(0, 1, 2'b00, 3'b001, 32'h102, 32'h0000_ABCD, 32'h0, 5'd0, 0, 0);  // SH
    run_op(1, 0, 2'b01, 3'b010, 32'h200, 32'h0, 32'h1357_9BDF, 5'd9, 1, 3);  // LW, 3 waits
    run_op(1, 0, 2'b01, 3'b010, 32'h102, 32'h0, 32'h1111_1111, 5'd3, 1, 2);  // misaligned LW
    run_op(1, 0, 2'b01, 3'b101, 32'h106, 32'h0, 32'h8001_7FFF, 5'd4, 1, 1);  // LHU upper
    run_op(1, 0, 2'b01, 3'b001, 32'h106, 32'h0, 32'h8001_7FFF, 5'd4, 1, 0);  // LH upper
    run_op(0, 1, 2'b00, 3'b000, 32'h301, 32'h0000_005A, 32'h0, 5'd0, 0, 0);  // SB lane 1
    run_op(0, 1, 2'b00, 3'b001, 32'h303, 32'h0000_1234, 32'h0, 5'd0, 0, 0);  // misaligned SH
    run_op(0, 0, 2'b00, 3'b000, 32'h0000_0007, 32'h0, 32'h0, 5'd8, 1, 0);    // ALU op
    run_op(0, 0, 2'b10, 3'b000, 32'h0000_0040, 32'h0, 32'h0, 5'd1, 1, 0);    // JAL-style

    // Reset asserted while a load is waiting: request vanishes at once, nothing reaches WB.
    valid_m = 1'b1; reg_write_m = 1'b1; result_src_m = 2'b01; mem_write_m = 1'b0;
    funct3_m = 3'b010; rd_m = 5'd12; alu_result_m = 32'h400;
    dmem_ready = 1'b0;
    #1;
    check("mid_req_before", dmem_req, 1);
    @(posedge clk); #1;
    check("mid_stall_wait", stall_m, 1);
    #2;
    srst = 1'b1;
    #1;
    check("mid_req", dmem_req, 0);
    check("mid_stall", stall_m, 0);
    check("mid_valid", valid_w, 0);
    check("mid_rd", rd_w, 0);
    check("mid_alu", alu_result_w, 0);
    dmem_ready = 1'b1;
    dmem_rdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    check("mid_late_valid", valid_w, 0);
    check("mid_late_read", read_data_w, 0);
    srst = 1'b0;
    valid_m = 1'b0;
    dmem_ready = 1'b0;
    @(posedge clk); #1;
    check("post_rst_valid", valid_w, 0);
    check("post_rst_req", dmem_req, 0);

    // Random traffic, including back-to-back zero-wait accesses.
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0: run_op(1, 0, 2'b01, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                  5'($urandom), 1, $urandom_range(0, 3));
        1: run_op(0, 1, 2'b00, 3'($urandom_range(0, 2)), $urandom, $urandom, $urandom,
                  5'($urandom), 0, $urandom_range(0, 3));
        2: run_op(0, 0, 2'b00, 3'($urandom), $urandom, $urandom, $urandom,
                  5'($urandom), 1, 0);
        default: run_op(0, 0, 2'b10, 3'($urandom), $urandom, $urandom, $urandom,
                        5'($urandom), 1, 0);
      endcase
    end

    valid_m = 1'b0;
    @(posedge clk); #1;
    check("drain_valid", valid_w, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
